stopwatch_bcd_counter: RTL and testbench

- Time base and BCD digit source for the stopwatch.
- Divides the system clock to a 0.1 s tick and counts elapsed time as four cascaded BCD digits (M:SS.t, max 9:59.9).
- Presents each digit as a 4-bit BCD code to the per-digit BCD-to-7-segment decoders.
- Owns the start/stop, clear and lap control state machine.

---
 rtl/stopwatch_bcd_counter_pkg.sv | 23 ++
 rtl/stopwatch_bcd_counter_if.sv | 22 ++
 rtl/stopwatch_bcd_counter_digit.sv | 26 ++
 rtl/stopwatch_bcd_counter.sv | 132 +++++++++++++
 tb/tb_stopwatch_bcd_counter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared types and constants for the stopwatch time base and digit counters.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        PAUSED   = 2'd2,
        LAP_HOLD = 2'd3
    } sw_state_t;

    localparam int DIG_W = 4;

    localparam logic [DIG_W-1:0] MAX_TENTH = 4'd9;
    localparam logic [DIG_W-1:0] MAX_SEC_O = 4'd9;
    localparam logic [DIG_W-1:0] MAX_SEC_T = 4'd5;
    localparam logic [DIG_W-1:0] MAX_MIN   = 4'd9;

    // Zero for a non-positive tick rate so the caller's range check fires instead of a divide by zero.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return (tick_hz > 0) ? (clk_hz / tick_hz) : 0;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_counter_if.sv
// Control pulses in, BCD digits and status out; master drives controls, slave is the counter.
interface stopwatch_bcd_counter_if;
    logic       i_start_stop;
    logic       i_clear;
    logic       i_lap;
    logic [3:0] o_dig_min;
    logic [3:0] o_dig_sec_t;
    logic [3:0] o_dig_sec_o;
    logic [3:0] o_dig_tenth;
    logic       o_running;
    logic       o_wrap;

    modport master (
        output i_start_stop, i_clear, i_lap,
        input  o_dig_min, o_dig_sec_t, o_dig_sec_o, o_dig_tenth, o_running, o_wrap
    );

    modport slave (
        input  i_start_stop, i_clear, i_lap,
        output o_dig_min, o_dig_sec_t, o_dig_sec_o, o_dig_tenth, o_running, o_wrap
    );
endinterface

// File: rtl/stopwatch_bcd_counter_digit.sv
// One BCD digit, 0..MAX, that rolls over to zero and raises carry on the increment that wraps it.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [DIG_W-1:0] MAX = 4'd9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [DIG_W-1:0] o_q,
    output logic             o_carry
);
    logic [DIG_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= '0;
        end else if (i_inc) begin
            r_q <= (r_q == MAX) ? '0 : r_q + DIG_W'(1);
        end
    end

    assign o_q     = r_q;
    assign o_carry = i_inc & (r_q == MAX);
endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch time base: prescaler, start/stop/clear/lap FSM and four cascaded BCD digits (M:SS.t).
// Lap freeze (LAP_HOLD + snapshot register) is built only when STOPWATCH_LAP_EN is defined.
//   state    | meaning
//   IDLE     | count zero, stopped
//   RUN      | counting, display live
//   PAUSED   | stopped, count and prescaler held
//   LAP_HOLD | counting, display shows the lap snapshot
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 10
) (
    input logic                    i_clk,
    input logic                    i_rst,
    stopwatch_bcd_counter_if.slave sw
);
    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;

    generate
        if (((TICK_HZ > 0) ? (CLK_HZ % TICK_HZ) : 1) != 0 || DIV < 2) begin : g_bad_div
            $error("stopwatch_bcd_counter: CLK_HZ/TICK_HZ must divide evenly and be >= 2");
        end
    endgenerate

    sw_state_t        r_state;
    logic [PW-1:0]    r_presc;
    logic             r_running;
    logic             r_wrap;
    logic             w_counting;
    logic             w_tick;
    logic             w_lap;
    logic [DIG_W-1:0] w_q_tenth, w_q_sec_o, w_q_sec_t, w_q_min;
    logic             w_c_tenth, w_c_sec_o, w_c_sec_t, w_c_min;
    logic [4*DIG_W-1:0] w_live;
    logic [4*DIG_W-1:0] w_disp;

    assign w_counting = (r_state == RUN) || (r_state == LAP_HOLD);
    assign w_tick     = w_counting && (r_presc == PW'(DIV - 1));

    // Clear beats a coincident tick because clr has priority over inc inside each digit.
    bcd_digit_counter #(.MAX(MAX_TENTH)) u_tenth (.i_clk(i_clk), .i_rst(i_rst), .i_clr(sw.i_clear),
        .i_inc(w_tick),    .o_q(w_q_tenth), .o_carry(w_c_tenth));
    bcd_digit_counter #(.MAX(MAX_SEC_O)) u_sec_o (.i_clk(i_clk), .i_rst(i_rst), .i_clr(sw.i_clear),
        .i_inc(w_c_tenth), .o_q(w_q_sec_o), .o_carry(w_c_sec_o));
    bcd_digit_counter #(.MAX(MAX_SEC_T)) u_sec_t (.i_clk(i_clk), .i_rst(i_rst), .i_clr(sw.i_clear),
        .i_inc(w_c_sec_o), .o_q(w_q_sec_t), .o_carry(w_c_sec_t));
    bcd_digit_counter #(.MAX(MAX_MIN))   u_min   (.i_clk(i_clk), .i_rst(i_rst), .i_clr(sw.i_clear),
        .i_inc(w_c_sec_t), .o_q(w_q_min),   .o_carry(w_c_min));

    assign w_live = {w_q_min, w_q_sec_t, w_q_sec_o, w_q_tenth};

`ifdef STOPWATCH_LAP_EN
    logic [4*DIG_W-1:0] r_snap;

    assign w_lap = sw.i_lap;

    // Captures the pre-tick count: the tick landing on this edge only reaches the live digits.
    always_ff @(posedge i_clk) begin
        if (i_rst || sw.i_clear) begin
            r_snap <= '0;
        end else if (r_state == RUN && !sw.i_start_stop && w_lap) begin
            r_snap <= w_live;
        end
    end

    assign w_disp = (r_state == LAP_HOLD) ? r_snap : w_live;
`else
    logic w_unused_lap;

    assign w_unused_lap = sw.i_lap;
    assign w_lap        = 1'b0;
    assign w_disp       = w_live;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst || sw.i_clear) begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_wrap <= w_c_min;
            if (w_counting) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            end
            case (r_state)
                IDLE: begin
                    if (sw.i_start_stop) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                        r_presc   <= '0;
                    end
                end
                RUN: begin
                    if (sw.i_start_stop) begin
                        r_state   <= PAUSED;
                        r_running <= 1'b0;
                    end else if (w_lap) begin
                        r_state <= LAP_HOLD;
                    end
                end
                PAUSED: begin
                    if (sw.i_start_stop) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                LAP_HOLD: begin
                    if (sw.i_start_stop) begin
                        r_state   <= PAUSED;
                        r_running <= 1'b0;
                    end else if (w_lap) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign sw.o_dig_min   = w_disp[15:12];
    assign sw.o_dig_sec_t = w_disp[11:8];
    assign sw.o_dig_sec_o = w_disp[7:4];
    assign sw.o_dig_tenth = w_disp[3:0];
    assign sw.o_running   = r_running;
    assign sw.o_wrap      = r_wrap;
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Scoreboard bench for stopwatch_bcd_counter at CLK_HZ=100, TICK_HZ=10; reference model counts elapsed tenths.
module tb_stopwatch_bcd_counter;
    localparam int DIV = 10;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    stopwatch_bcd_counter_if sw ();

    stopwatch_bcd_counter #(.CLK_HZ(100), .TICK_HZ(10)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .sw(sw)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [17:0] exp_q[$];

    int m_mode  = M_IDLE;
    int m_presc = 0;
    int m_e     = 0;
    int m_snap  = 0;
    bit m_wrap  = 1'b0;

    function automatic logic [17:0] pack(input int e, input bit run, input bit wr);
        logic [3:0] mn, st, so, t;
        mn = 4'((e / 600) % 10);
        st = 4'((e / 100) % 6);
        so = 4'((e / 10) % 10);
        t  = 4'(e % 10);
        return {mn, st, so, t, run, wr};
    endfunction

    function automatic logic [17:0] dut_out();
        return {sw.o_dig_min, sw.o_dig_sec_t, sw.o_dig_sec_o, sw.o_dig_tenth, sw.o_running, sw.o_wrap};
    endfunction

    // Reference behaviour in terms of total elapsed tenths (mod 10 minutes).
    task automatic model_step(input bit ss, input bit clr, input bit lp, input bit rs);
        bit cnt, tk;
        int olde;
        int disp;
        cnt  = (m_mode == M_RUN) || (m_mode == M_LAP);
        tk   = cnt && (m_presc == DIV - 1);
        olde = m_e;
        if (rs || clr) begin
            m_mode = M_IDLE; m_presc = 0; m_e = 0; m_snap = 0; m_wrap = 1'b0;
        end else begin
            m_wrap = tk && (olde == 5999);
            if (cnt) m_presc = tk ? 0 : m_presc + 1;
            if (tk) m_e = (olde + 1) % 6000;
            case (m_mode)
                M_IDLE:  if (ss) begin m_mode = M_RUN; m_presc = 0; end
                M_RUN:   if (ss) m_mode = M_PAUSE;
                         else if (lp && LAP_EN) begin m_mode = M_LAP; m_snap = olde; end
                M_PAUSE: if (ss) m_mode = M_RUN;
                default: if (ss) m_mode = M_PAUSE;
                         else if (lp) m_mode = M_RUN;
            endcase
        end
        disp = (m_mode == M_LAP) ? m_snap : m_e;
        exp_q.push_back(pack(disp, (m_mode == M_RUN) || (m_mode == M_LAP), m_wrap));
    endtask

    task automatic step(input bit ss, input bit clr, input bit lp, input bit rs);
        sw.i_start_stop = ss;
        sw.i_clear      = clr;
        sw.i_lap        = lp;
        rst             = rs;
        @(posedge clk);
        model_step(ss, clr, lp, rs);
        #1;
        sw.i_start_stop = 1'b0;
        sw.i_clear      = 1'b0;
        sw.i_lap        = 1'b0;
        rst             = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [17:0] req);
        logic [17:0] act;
        act = dut_out();
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual digits=%h run=%b wrap=%b, required digits=%h run=%b wrap=%b",
                     name, act[17:2], act[1], act[0], req[17:2], req[1], req[0]);
        end
    endtask

    always @(negedge clk) begin
        logic [17:0] e;
        logic [17:0] a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_out();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL scoreboard cyc=%0d: actual digits=%h run=%b wrap=%b, required digits=%h run=%b wrap=%b",
                         cyc, a[17:2], a[1], a[0], e[17:2], e[1], e[0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        sw.i_start_stop = 1'b0;
        sw.i_clear      = 1'b0;
        sw.i_lap        = 1'b0;

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset", pack(0, 1'b0, 1'b0));
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, ($urandom_range(0, 9) == 0), 1'b0);
        chk("idle50", pack(0, 1'b0, 1'b0));

        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(95);
        chk("run95", pack(9, 1'b1, 1'b0));
        idle(5);
        chk("run100", pack(10, 1'b1, 1'b0));

        for (int i = 0; i < 70000 && !m_wrap; i++) idle(1);
        chk("wrap_high", pack(0, 1'b1, 1'b1));
        idle(1);
        chk("wrap_low", pack(0, 1'b1, 1'b0));

        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(120);
        chk("run_0_01_2", pack(12, 1'b1, 1'b0));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(100);
        chk("paused_hold", pack(12, 1'b0, 1'b0));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(8);
        chk("resume_pre_tick", pack(12, 1'b1, 1'b0));
        idle(1);
        chk("resume_tick", pack(13, 1'b1, 1'b0));

        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(50);
        chk("lap_start", pack(5, 1'b1, 1'b0));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(300);
        chk("lap_hold", pack(LAP_EN ? 5 : 35, 1'b1, 1'b0));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap_release", pack(35, 1'b1, 1'b0));

        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(9);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("clear_vs_ss", pack(0, 1'b0, 1'b0));
        idle(20);
        chk("clear_stays_idle", pack(0, 1'b0, 1'b0));

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 499) == 0);
        end

        idle(2);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
